// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared instruction-word constants for the TPU instruction
//               queue: word width, opcode field values, NOP word, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  localparam int INSTR_W = 16;

  // Opcode lives in the top two bits of every instruction word.
  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_COMPUTE = 2'b11;

  localparam logic [INSTR_W-1:0] NOP_WORD = '0;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_WAIT  = 1'b1
  } iq_state_t;

  function automatic logic [1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[INSTR_W-1 -: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tpu_sync_fifo
// Description : Single-clock FIFO, DEPTH x WIDTH. Pointers carry one extra
//               MSB so full and empty are told apart without a counter.
//               Read data is the head entry, valid whenever !empty.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  // A simultaneous pop frees a slot, so a full FIFO may still take a push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && !clear && (!full || pop_ok);

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer update; clear discards everything and beats any push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tpu_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tpu_instr_queue
// Description : Host-to-TPU instruction queue. Words are popped one per cycle
//               onto a registered tpu_instr port; after every COMPUTE word the
//               queue stalls for COMPUTE_WAIT cycles, driving NOPs.
//               Optional feature macro: TPU_IQ_STATS_EN adds issued_count,
//               a wrapping count of non-NOP words issued.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_instr_queue
  import tpu_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int COMPUTE_WAIT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [15:0]              tpu_instr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
`ifdef TPU_IQ_STATS_EN
  ,
  output logic [15:0]              issued_count
`endif
);

  localparam int CNT_W = 8;

  iq_state_t          state;
  logic [CNT_W-1:0]   wait_cnt;
  logic [INSTR_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  // in_ready depends only on registered pointers, never on in_valid.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_ISSUE) && !fifo_empty && !flush;
  assign busy     = !fifo_empty || (state == ST_WAIT);

  tpu_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   (in_instr),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Issue/stall FSM: pops the head onto tpu_instr, or holds NOPs during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ISSUE;
      wait_cnt  <= '0;
      tpu_instr <= NOP_WORD;
    end else if (flush) begin
      state     <= ST_ISSUE;
      wait_cnt  <= '0;
      tpu_instr <= NOP_WORD;
    end else begin
      case (state)
        ST_ISSUE: begin
          if (pop) begin
            tpu_instr <= head;
            if (opcode_of(head) == OP_COMPUTE) begin
              wait_cnt <= CNT_W'(COMPUTE_WAIT);
              state    <= ST_WAIT;
            end
          end else begin
            tpu_instr <= NOP_WORD;
          end
        end
        ST_WAIT: begin
          // Leaving on the edge that reaches zero yields exactly COMPUTE_WAIT NOPs.
          tpu_instr <= NOP_WORD;
          wait_cnt  <= wait_cnt - CNT_W'(1);
          if (wait_cnt == CNT_W'(1)) begin
            state <= ST_ISSUE;
          end
        end
        default: begin
          state     <= ST_ISSUE;
          tpu_instr <= NOP_WORD;
        end
      endcase
    end
  end

`ifdef TPU_IQ_STATS_EN
  // Counts non-NOP words as they are popped onto the TPU port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_count <= '0;
    end else if (flush) begin
      issued_count <= '0;
    end else if (pop && (opcode_of(head) != OP_NOP)) begin
      issued_count <= issued_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tpu_instr_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_instr_queue
// Description : Self-checking bench for tpu_instr_queue. A queue-based model
//               predicts every output; directed steps add explicit constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_instr_queue;

  localparam int DEPTH = 8;
  localparam int CW    = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [15:0] tpu_instr;
  logic [3:0]  level;
  logic        busy;
`ifdef TPU_IQ_STATS_EN
  logic [15:0] issued_count;
`endif

  always #5 clk = ~clk;

  tpu_instr_queue #(.DEPTH(DEPTH), .COMPUTE_WAIT(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .flush     (flush),
    .tpu_instr (tpu_instr),
    .level     (level),
    .busy      (busy)
`ifdef TPU_IQ_STATS_EN
    ,
    .issued_count (issued_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a plain queue of pending words plus remaining stall NOPs.
  logic [15:0] mq[$];
  int          wait_left = 0;
  logic [15:0] exp_instr = '0;
  int          exp_stats = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    wait_left = 0;
    exp_instr = '0;
    exp_stats = 0;
  endtask

  // One clock edge of the model; returns whether the host word was taken.
  function automatic bit model_edge(input bit v, input logic [15:0] w, input bit f);
    bit acc;
    acc = v && (mq.size() < DEPTH) && !f;
    if (f) begin
      mq.delete();
      wait_left = 0;
      exp_instr = '0;
      exp_stats = 0;
    end else begin
      if (wait_left > 0) begin
        exp_instr = '0;
        wait_left--;
      end else if (mq.size() > 0) begin
        exp_instr = mq.pop_front();
        if (exp_instr[15:14] == 2'b11) wait_left = CW;
        if (exp_instr[15:14] != 2'b00) exp_stats = (exp_stats + 1) % 65536;
      end else begin
        exp_instr = '0;
      end
      if (acc) mq.push_back(w);
    end
    return acc;
  endfunction

  // Drive one cycle of inputs, advance one edge, compare all outputs to the model.
  task automatic cycle(input bit v, input logic [15:0] w, input bit f, output bit acc);
    in_valid = v;
    in_instr = w;
    flush    = f;
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    @(posedge clk);
    acc = model_edge(v, w, f);
    #1;
    chk("tpu_instr", 32'(tpu_instr), 32'(exp_instr));
    chk("level", 32'(level), 32'(mq.size()));
    chk("busy", 32'(busy), 32'((mq.size() > 0) || (wait_left > 0)));
`ifdef TPU_IQ_STATS_EN
    chk("issued_count", 32'(issued_count), 32'(exp_stats));
`endif
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, acc);
  endtask

  // Run idle cycles until the queue has drained and any stall has ended.
  task automatic drain();
    int guard;
    guard = 0;
    while (((mq.size() > 0) || (wait_left > 0)) && guard < 200) begin
      idle(1);
      guard++;
    end
    chk("drain_timeout", 32'(guard < 200), 32'd1);
  endtask

  // Offer a word and hold it stable until it is accepted.
  task automatic push_word(input logic [15:0] w);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      cycle(1'b1, w, 1'b0, acc);
      tries++;
    end
    chk("push_timeout", 32'(acc), 32'd1);
  endtask

  initial begin : main
    bit          acc;
    bit          pend;
    logic [15:0] pw;
    logic [15:0] seen;
    int          nops;

    // ---------------- reset state ----------------
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tpu_instr", 32'(tpu_instr), 32'h0000);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    model_reset();
    idle(2);

    // ---------------- passthrough ----------------
    cycle(1'b1, 16'h4100, 1'b0, acc);
    chk("pt_first_edge", 32'(tpu_instr), 32'h0000);
    cycle(1'b1, 16'h4201, 1'b0, acc);
    chk("pt_4100", 32'(tpu_instr), 32'h4100);
    cycle(1'b1, 16'h8003, 1'b0, acc);
    chk("pt_4201", 32'(tpu_instr), 32'h4201);
    idle(1);
    chk("pt_8003", 32'(tpu_instr), 32'h8003);
    idle(1);
    chk("pt_empty_nop", 32'(tpu_instr), 32'h0000);

    // ---------------- compute stall ----------------
    cycle(1'b1, 16'hC000, 1'b0, acc);
    cycle(1'b1, 16'h4005, 1'b0, acc);
    chk("cs_compute", 32'(tpu_instr), 32'hC000);
    nops = 0;
    seen = 16'h0000;
    for (int i = 0; i < 20 && seen == 16'h0000; i++) begin
      idle(1);
      seen = tpu_instr;
      if (seen == 16'h0000) nops++;
    end
    chk("cs_nop_count", 32'(nops), 32'd7);
    chk("cs_after_wait", 32'(seen), 32'h4005);
    drain();

    // ---------------- full queue ----------------
    cycle(1'b1, 16'hC000, 1'b0, acc);
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h5000 + 16'(i), 1'b0, acc);
    chk("full_level", 32'(level), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'h5008, 1'b0, acc);
    chk("full_9th_dropped", 32'(acc), 32'd0);
    chk("full_pop_level", 32'(level), 32'd7);
    cycle(1'b1, 16'h5008, 1'b0, acc);
    chk("full_9th_taken", 32'(acc), 32'd1);
    drain();

    // ---------------- flush during wait ----------------
    cycle(1'b1, 16'hC000, 1'b0, acc);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h6000 + 16'(i), 1'b0, acc);
    chk("fl_level5", 32'(level), 32'd5);
    chk("fl_busy", 32'(busy), 32'd1);
    cycle(1'b1, 16'h7777, 1'b1, acc);
    chk("fl_level0", 32'(level), 32'd0);
    chk("fl_tpu_nop", 32'(tpu_instr), 32'h0000);
    chk("fl_busy0", 32'(busy), 32'd0);
    idle(2);
    chk("fl_word_discarded", 32'(level), 32'd0);
    cycle(1'b1, 16'h4321, 1'b0, acc);
    idle(1);
    chk("fl_issue_state", 32'(tpu_instr), 32'h4321);

    // ---------------- randomized traffic ----------------
    pend = 1'b0;
    pw   = '0;
    for (int i = 0; i < 400; i++) begin
      bit f;
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend = 1'b1;
        pw = 16'($urandom);
        if ($urandom_range(0, 7) != 0 && pw[15:14] == 2'b11) pw[15:14] = 2'b01;
      end
      f = ($urandom_range(0, 63) == 0);
      cycle(pend, pw, f, acc);
      if (acc) pend = 1'b0;
    end
    drain();

    // ---------------- reset mid-operation ----------------
    cycle(1'b1, 16'hC000, 1'b0, acc);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h4400 + 16'(i), 1'b0, acc);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_tpu_instr", 32'(tpu_instr), 32'h0000);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    idle(3);
    chk("postrst_tpu", 32'(tpu_instr), 32'h0000);

`ifdef TPU_IQ_STATS_EN
    // ---------------- issue statistics ----------------
    push_word(16'h4100);
    push_word(16'h0000);
    push_word(16'h8200);
    push_word(16'h0000);
    push_word(16'hC000);
    drain();
    chk("stats_three", 32'(issued_count), 32'd3);
    for (int i = 0; i < 65532; i++) cycle(1'b1, 16'h4000, 1'b0, acc);
    drain();
    chk("stats_ffff", 32'(issued_count), 32'hFFFF);
    push_word(16'h4001);
    drain();
    chk("stats_wrap", 32'(issued_count), 32'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/tpu_instr_queue.md
TPU_INSTR_QUEUE -- requirements
Module: tpu_instr_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter COMPUTE_WAIT, default 7, meaning NOP cycles inserted after each COMPUTE issue (1..255).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning host offers in_instr.
REQ-006 SHALL have port in_instr, input, 16, meaning host instruction word.
REQ-007 SHALL have port in_ready, output, 1, meaning queue accepts; equals !full.
REQ-008 SHALL have port flush, input, 1, meaning discard queue and abort wait.
REQ-009 SHALL have port tpu_instr, output, 16, meaning registered instruction driven to the tpu instruction port every cycle.
REQ-010 SHALL have port level, output, $clog2(DEPTH)+1, meaning current occupancy.
REQ-011 SHALL have port busy, output, 1, meaning queue non-empty or in WAIT.

Function
REQ-012 SHALL decode opcode as tpu_instr[15:14]: 2'b00 NOP, 2'b11 COMPUTE, others pass-through load/read.
REQ-013 SHALL accept a word on any edge with in_valid && in_ready; no combinational in_valid-to-in_ready path.
REQ-014 SHALL implement FSM: ISSUE (pop one word per cycle if non-empty, else drive NOP) and WAIT (drive NOP, decrement counter).
REQ-015 SHALL pop on the same edge the word is registered onto tpu_instr; latency enqueue-to-tpu_instr is 1 cycle when empty and in ISSUE.
REQ-016 SHALL on issuing COMPUTE load wait counter with COMPUTE_WAIT and enter WAIT next cycle.
REQ-017 SHALL in WAIT drive 16'h0000 and not pop; return to ISSUE on the edge the counter reaches 0, after exactly COMPUTE_WAIT NOP cycles.
REQ-018 SHALL allow push and pop on the same edge when full (level unchanged); push into empty while popping impossible.
REQ-019 SHALL drop pushes when full (in_ready low); host holds in_valid/in_instr stable until accepted.
REQ-020 SHALL on flush clear pointers, level=0, go to ISSUE, drive NOP next cycle; flush wins over simultaneous push.
REQ-021 SHALL wrap read/write pointers modulo DEPTH, with extra MSB distinguishing full from empty.
REQ-022 SHALL pass in_instr bits unmodified; NOP words from host are issued like any word (consume a cycle).

Reset
REQ-023 SHALL on rst asserted immediately force tpu_instr=16'h0000, level=0, busy=0, FSM=ISSUE, counter=0, pointers=0.
REQ-024 SHALL treat rst mid-WAIT or mid-queue as discard; contents not recovered; in_ready=1 during and after reset.

Configuration
REQ-025 SHALL with TPU_IQ_STATS_EN defined add output issued_count (16-bit, wrapping, reset 0) counting non-NOP words issued, cleared by flush.
REQ-026 SHALL without TPU_IQ_STATS_EN have no issued_count port and no counter logic.

Structure
REQ-027 SHALL place opcode constants (OP_NOP, OP_COMPUTE), instruction width 16 and NOP word in shared package tpu_pkg.
REQ-028 SHALL use one sub-module, tpu_sync_fifo (DEPTH x 16, push/pop/full/empty/level); FSM and counter in top.

Verification
REQ-029 SHALL test reset: assert rst mid-operation -> tpu_instr=0000, level=0, busy=0 same cycle.
REQ-030 SHALL test passthrough: push 4100,4201,8003 on empty queue -> tpu_instr shows them on consecutive cycles, each 1 cycle after push.
REQ-031 SHALL test compute stall: push C000,4005 -> C000 issued, then exactly 7 cycles 0000, then 4005.
REQ-032 SHALL test full: push 9 words with no drain (inside WAIT) -> in_ready low after 8th, level=8, 9th accepted only after pop.
REQ-033 SHALL test flush during WAIT with level=5 and push -> next cycle level=0, tpu_instr=0000, FSM ISSUE, pushed word discarded.
REQ-034 SHALL test TPU_IQ_STATS_EN build: issue 3 non-NOP plus 2 NOP words -> issued_count=3; wrap from FFFF to 0000.
